// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C_driver master between NUM_REQ requesters.
// Optional driver-wait timeout/abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PTR_W          = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic                   err,
  output logic                   arb_busy,
  output logic                   drv_start,
  output logic                   drv_rw,
  output logic [6:0]             drv_addr,
  output logic [7:0]             drv_wdata,
  input  logic                   drv_busy,
  input  logic [7:0]             drv_rdata
);

  localparam int unsigned SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("i2c_bus_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("i2c_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_COMPLETE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [7:0]         r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;
  logic               r_arb_busy, w_arb_busy_nxt;
  logic               r_drv_start, w_drv_start_nxt;
  logic               r_drv_rw, w_drv_rw_nxt;
  logic [6:0]         r_drv_addr, w_drv_addr_nxt;
  logic [7:0]         r_drv_wdata, w_drv_wdata_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_gidx, w_gidx_nxt;

  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [SUM_W-1:0]   w_cand;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic               r_abort, w_abort_nxt;
  logic               w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`endif

  // Rotating priority search: first asserted request at or above rr_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + SUM_W'(k);
      if (w_cand >= NUM_REQ_S) begin
        w_cand = w_cand - NUM_REQ_S;
      end
      if (!w_found && req[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[PTR_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every register has its hold value as default.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_done_nxt      = '0;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = 1'b0;
    w_drv_start_nxt = r_drv_start;
    w_drv_rw_nxt    = r_drv_rw;
    w_drv_addr_nxt  = r_drv_addr;
    w_drv_wdata_nxt = r_drv_wdata;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gidx_nxt      = r_gidx;
`ifdef I2C_ARB_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_abort_nxt     = r_abort;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt       = NUM_REQ'(1'b1) << w_sel;
          w_gidx_nxt      = w_sel;
          w_drv_rw_nxt    = req_rw[w_sel];
          w_drv_addr_nxt  = req_addr[32'(w_sel)*7 +: 7];
          w_drv_wdata_nxt = req_wdata[32'(w_sel)*8 +: 8];
          w_state_nxt     = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        w_drv_start_nxt = 1'b1;
        w_state_nxt     = ST_WAIT_ACCEPT;
`ifdef I2C_ARB_TIMEOUT_EN
        w_tmo_cnt_nxt   = '0;
        w_abort_nxt     = 1'b0;
`endif
      end

      ST_WAIT_ACCEPT: begin
        if (drv_busy) begin
          w_drv_start_nxt = 1'b0;
          w_state_nxt     = ST_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
          w_tmo_cnt_nxt   = '0;
        end else if (w_tmo_hit) begin
          w_drv_start_nxt = 1'b0;
          w_abort_nxt     = 1'b1;
          w_state_nxt     = ST_COMPLETE;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + TMO_W'(1);
`endif
        end
      end

      ST_WAIT_DONE: begin
        if (!drv_busy) begin
          w_rdata_nxt = r_drv_rw ? drv_rdata : 8'h00;
          w_state_nxt = ST_COMPLETE;
`ifdef I2C_ARB_TIMEOUT_EN
        end else if (w_tmo_hit) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_COMPLETE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
`endif
        end
      end

      ST_COMPLETE: begin
        w_done_nxt   = r_gnt;
        w_gnt_nxt    = '0;
        w_rr_ptr_nxt = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);
        w_state_nxt  = ST_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
        w_err_nxt    = r_abort;
        w_abort_nxt  = 1'b0;
`endif
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = '0;
        w_drv_start_nxt = 1'b0;
      end
    endcase

    w_arb_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_arb_busy  <= 1'b0;
      r_drv_start <= 1'b0;
      r_drv_rw    <= 1'b0;
      r_drv_addr  <= '0;
      r_drv_wdata <= '0;
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_arb_busy  <= w_arb_busy_nxt;
      r_drv_start <= w_drv_start_nxt;
      r_drv_rw    <= w_drv_rw_nxt;
      r_drv_addr  <= w_drv_addr_nxt;
      r_drv_wdata <= w_drv_wdata_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_abort   <= w_abort_nxt;
    end
  end
`endif

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign arb_busy  = r_arb_busy;
  assign drv_start = r_drv_start;
  assign drv_rw    = r_drv_rw;
  assign drv_addr  = r_drv_addr;
  assign drv_wdata = r_drv_wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a simple behavioural I2C_driver busy/data model.
// Timeout expectations depend on whether I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_rw;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        arb_busy;
  logic        drv_start;
  logic        drv_rw;
  logic [6:0]  drv_addr;
  logic [7:0]  drv_wdata;
  logic        drv_busy;
  logic [7:0]  drv_rdata;

  int total;
  int bad;

  // Driver model knobs
  logic        m_en;
  int          m_len;
  logic [7:0]  m_data;

  i2c_bus_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .arb_busy  (arb_busy),
    .drv_start (drv_start),
    .drv_rw    (drv_rw),
    .drv_addr  (drv_addr),
    .drv_wdata (drv_wdata),
    .drv_busy  (drv_busy),
    .drv_rdata (drv_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver model: accepts drv_start one cycle after seeing it, stays busy m_len cycles.
  initial begin
    drv_busy  = 1'b0;
    drv_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (m_en && drv_start && !drv_busy) begin
        #1;
        drv_busy  = 1'b1;
        drv_rdata = m_data;
        repeat (m_len) @(posedge clk);
        #1;
        drv_busy = 1'b0;
      end
    end
  end

  task automatic wait_done(input int limit, output int cyc, output logic [3:0] d);
    cyc = 0;
    d   = 4'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done !== 4'b0) begin
        d = done;
        break;
      end
    end
  endtask

  task automatic wait_busy_fall(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (!drv_busy) break;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (gnt !== 4'b0)       begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (done !== 4'b0)      begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    total++; if (rdata !== 8'h00)    begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (arb_busy !== 1'b0)  begin bad++; $display("FAIL reset_arb_busy got=%b want=0", arb_busy); end
    total++; if (drv_start !== 1'b0) begin bad++; $display("FAIL reset_drv_start got=%b want=0", drv_start); end
    total++; if ({drv_rw, drv_addr, drv_wdata} !== 16'h0)
      begin bad++; $display("FAIL reset_drv_fields got=%h want=0000", {drv_rw, drv_addr, drv_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int cyc;
    logic [3:0] d;
    m_en = 1'b1; m_len = 40; m_data = 8'hA5;
    req_rw = 4'b0001;
    req_addr[6:0] = 7'h50;
    req = 4'b0001;
    @(negedge clk);
    total++; if (gnt !== 4'b0001)    begin bad++; $display("FAIL read_gnt got=%b want=0001", gnt); end
    total++; if (drv_addr !== 7'h50) begin bad++; $display("FAIL read_drv_addr got=%h want=50", drv_addr); end
    total++; if (drv_rw !== 1'b1)    begin bad++; $display("FAIL read_drv_rw got=%b want=1", drv_rw); end
    total++; if (drv_start !== 1'b0) begin bad++; $display("FAIL read_start_early got=%b want=0", drv_start); end
    total++; if (arb_busy !== 1'b1)  begin bad++; $display("FAIL read_arb_busy got=%b want=1", arb_busy); end
    req = 4'b0000;
    @(negedge clk);
    total++; if (drv_start !== 1'b1) begin bad++; $display("FAIL read_start_latency got=%b want=1", drv_start); end
    @(negedge clk);
    total++; if ({drv_busy, drv_start} !== 2'b11)
      begin bad++; $display("FAIL read_start_held got=%b want=11", {drv_busy, drv_start}); end
    @(negedge clk);
    total++; if (drv_start !== 1'b0) begin bad++; $display("FAIL read_start_drop got=%b want=0", drv_start); end
    wait_busy_fall(100, cyc);
    total++; if (drv_busy !== 1'b0)  begin bad++; $display("FAIL read_busy_fall got=%b want=0", drv_busy); end
    wait_done(10, cyc, d);
    total++; if (d !== 4'b0001)      begin bad++; $display("FAIL read_done got=%b want=0001", d); end
    total++; if (cyc !== 2)          begin bad++; $display("FAIL read_done_latency got=%0d want=2", cyc); end
    total++; if (rdata !== 8'hA5)    begin bad++; $display("FAIL read_rdata got=%h want=a5", rdata); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL read_err got=%b want=0", err); end
    total++; if (gnt !== 4'b0)       begin bad++; $display("FAIL read_gnt_clear got=%b want=0000", gnt); end
    @(negedge clk);
    total++; if (done !== 4'b0)      begin bad++; $display("FAIL read_done_pulse got=%b want=0000", done); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_d;
    logic [3:0] got;
    logic [6:0] got_addr;
    logic [6:0] exp_addr;
    logic multi;
    apply_reset();
    m_en = 1'b1; m_len = 3; m_data = 8'h11;
    req_rw = 4'b1111;
    req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    req = 4'b1111;
    multi = 1'b0;
    for (int t = 0; t < 5; t++) begin
      exp_d = 4'b0001 << order[t];
      exp_addr = 7'h10 + 7'(order[t]);
      got = 4'b0;
      got_addr = 7'h00;
      for (int c = 0; c < 100 && got == 4'b0; c++) begin
        @(negedge clk);
        if ($countones(gnt) > 1) multi = 1'b1;
        if (done !== 4'b0) begin
          got = done;
          got_addr = drv_addr;
        end
      end
      total++; if (got !== exp_d)
        begin bad++; $display("FAIL rr_done_%0d got=%b want=%b", t, got, exp_d); end
      total++; if (got_addr !== exp_addr)
        begin bad++; $display("FAIL rr_addr_%0d got=%h want=%h", t, got_addr, exp_addr); end
    end
    req = 4'b0000;
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL rr_multi_hot got=%b want=0", multi); end
    @(negedge clk);
    total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", arb_busy); end
  endtask

  task automatic test_write();
    int cyc;
    logic [3:0] d;
    m_en = 1'b1; m_len = 5; m_data = 8'hEE;
    req_rw = 4'b0000;
    req_wdata[23:16] = 8'h3C;
    req_addr[20:14] = 7'h2A;
    req = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100)      begin bad++; $display("FAIL wr_gnt got=%b want=0100", gnt); end
    total++; if (drv_wdata !== 8'h3C)  begin bad++; $display("FAIL wr_drv_wdata got=%h want=3c", drv_wdata); end
    total++; if (drv_rw !== 1'b0)      begin bad++; $display("FAIL wr_drv_rw got=%b want=0", drv_rw); end
    req = 4'b0000;
    wait_done(100, cyc, d);
    total++; if (d !== 4'b0100)        begin bad++; $display("FAIL wr_done got=%b want=0100", d); end
    total++; if (rdata !== 8'h00)      begin bad++; $display("FAIL wr_rdata got=%h want=00", rdata); end
    @(negedge clk);
  endtask

  task automatic test_no_cancel();
    int cyc;
    logic [3:0] d;
    m_en = 1'b1; m_len = 20; m_data = 8'h5A;
    req_rw = 4'b0010;
    req_addr[13:7] = 7'h22;
    req = 4'b0010;
    cyc = 0;
    while (cyc < 50 && !(drv_busy && !drv_start)) begin
      @(negedge clk);
      cyc++;
    end
    total++; if ({drv_busy, drv_start} !== 2'b10)
      begin bad++; $display("FAIL nc_wait_done_state got=%b want=10", {drv_busy, drv_start}); end
    req = 4'b0000;
    req_addr[13:7] = 7'h7F;
    @(negedge clk);
    total++; if (drv_addr !== 7'h22)  begin bad++; $display("FAIL nc_drv_addr got=%h want=22", drv_addr); end
    wait_done(100, cyc, d);
    total++; if (d !== 4'b0010)       begin bad++; $display("FAIL nc_done got=%b want=0010", d); end
    total++; if (rdata !== 8'h5A)     begin bad++; $display("FAIL nc_rdata got=%h want=5a", rdata); end
    @(negedge clk);
    total++; if (arb_busy !== 1'b0)   begin bad++; $display("FAIL nc_idle got=%b want=0", arb_busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [3:0] d;
    logic saw_done;
    m_en = 1'b1; m_len = 30; m_data = 8'h99;
    req_rw = 4'b1010;
    req = 4'b1000;
    cyc = 0;
    while (cyc < 50 && !(drv_busy && !drv_start)) begin
      @(negedge clk);
      cyc++;
    end
    req = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 4'b0)       begin bad++; $display("FAIL rm_gnt got=%b want=0000", gnt); end
    total++; if (drv_start !== 1'b0) begin bad++; $display("FAIL rm_drv_start got=%b want=0", drv_start); end
    total++; if (arb_busy !== 1'b0)  begin bad++; $display("FAIL rm_arb_busy got=%b want=0", arb_busy); end
    saw_done = (done !== 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 100 && drv_busy) begin
      @(negedge clk);
      cyc++;
      if (done !== 4'b0) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0)  begin bad++; $display("FAIL rm_no_done got=%b want=0", saw_done); end
    m_len = 4; m_data = 8'h77;
    req = 4'b1010;
    @(negedge clk);
    total++; if (gnt !== 4'b0010)    begin bad++; $display("FAIL rm_regrant got=%b want=0010", gnt); end
    req = 4'b0000;
    wait_done(100, cyc, d);
    total++; if (d !== 4'b0010)      begin bad++; $display("FAIL rm_done got=%b want=0010", d); end
    total++; if (rdata !== 8'h77)    begin bad++; $display("FAIL rm_rdata got=%h want=77", rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi_cnt;
    int cyc;
    logic [3:0] d;
    m_en = 1'b0;
    req_rw = 4'b0001;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    hi_cnt = 0;
    d = 4'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cyc = 0;
    while (cyc < 200 && d == 4'b0) begin
      @(negedge clk);
      cyc++;
      if (drv_start) hi_cnt++;
      if (done !== 4'b0) d = done;
    end
    total++; if (d !== 4'b0001)      begin bad++; $display("FAIL to_done got=%b want=0001", d); end
    total++; if (err !== 1'b1)       begin bad++; $display("FAIL to_err got=%b want=1", err); end
    total++; if (hi_cnt !== 50)      begin bad++; $display("FAIL to_wait_cycles got=%0d want=50", hi_cnt); end
    total++; if (drv_start !== 1'b0) begin bad++; $display("FAIL to_drv_start got=%b want=0", drv_start); end
    total++; if (rdata !== 8'h77)    begin bad++; $display("FAIL to_rdata got=%h want=77", rdata); end
    @(negedge clk);
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL to_err_pulse got=%b want=0", err); end
`else
    for (cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (drv_start) hi_cnt++;
      if (done !== 4'b0) d = done;
    end
    total++; if (d !== 4'b0)         begin bad++; $display("FAIL to_no_done got=%b want=0000", d); end
    total++; if (hi_cnt !== 1000)    begin bad++; $display("FAIL to_start_held got=%0d want=1000", hi_cnt); end
    total++; if (arb_busy !== 1'b1)  begin bad++; $display("FAIL to_still_busy got=%b want=1", arb_busy); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL to_err got=%b want=0", err); end
    apply_reset();
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_en = 1'b0;
    m_len = 1;
    m_data = 8'h00;
    rst_n = 1'b0;
    req = 4'b0;
    req_rw = 4'b0;
    req_addr = '0;
    req_wdata = '0;
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_no_cancel();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C_driver master between NUM_REQ independent requesters using round-robin arbitration.
- Captures a winner's transaction (RW, 7-bit address, write byte) and drives the driver's start/command inputs.
- Tracks the driver's busy handshake to completion, then returns the read byte with a one-cycle done pulse to the granted requester.
- Sits between client blocks (sensor pollers, config loaders) and the single I2C_driver instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PTR_W, $clog2(NUM_REQ), width of grant index / round-robin pointer.
- TIMEOUT_CYCLES, 200000, clk cycles allowed in any driver-wait state before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester transaction request, level
- req_rw  in  NUM_REQ  per-requester RW bit (1 = read)
- req_addr  in  7*NUM_REQ  per-requester slave address, requester i at [7i+6:7i]
- req_wdata  in  8*NUM_REQ  per-requester write byte, requester i at [8i+7:8i]
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse, same bit as gnt
- rdata  out  8  read byte, valid in the done cycle and held until the next completion
- err  out  1  abort flag, valid with done
- arb_busy  out  1  high in any state other than IDLE
- drv_start  out  1  to I2C_driver I2C_Start
- drv_rw  out  1  to I2C_driver RW
- drv_addr  out  7  to I2C_driver slave_addr
- drv_wdata  out  8  to I2C_driver data_in
- drv_busy  in  1  from I2C_driver busy
- drv_rdata  in  8  from I2C_driver data_out

Behaviour:
- Reset: all rst_n-sampled flops update only on posedge clk.
  - gnt=0, done=0, rdata=0, err=0, arb_busy=0, drv_start=0, drv_rw=0, drv_addr=0, drv_wdata=0, rr_ptr=0, state=IDLE.
  - Reset mid-transaction returns to IDLE in 1 cycle and drops drv_start. No done is issued; the driver's own reset is a separate concern.
- FSM states: IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE, COMPLETE.
- IDLE: if req != 0, select the first set bit searching from rr_ptr upward with wrap. In the same cycle:
  - register gnt (one-hot), drv_rw, drv_addr and drv_wdata from that requester;
  - go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: drv_start=1 for exactly this cycle's registered output; go to WAIT_ACCEPT.
- WAIT_ACCEPT: hold drv_start=1 until drv_busy=1 is sampled, then drv_start=0 next cycle and go to WAIT_DONE.
- WAIT_DONE: wait for drv_busy=0. Then latch rdata <= drv_rdata, or 8'h00 when drv_rw=0. Go to COMPLETE.
- COMPLETE: done[g]=1 for one cycle, err=0, gnt cleared the same cycle, rr_ptr <= (g+1) mod NUM_REQ, go to IDLE.
- Latency:
  - grant to drv_start high: 1 cycle;
  - drv_busy fall to done: 2 cycles;
  - done to next grant: ≥1 cycle, since IDLE re-arbitrates the cycle after COMPLETE.
- Command fields are captured at grant. Requester changes to req_* after grant are ignored.
- A requester dropping req after grant does not cancel; the transaction completes and done still pulses.
- Simultaneous requests: exactly one grant. A requester whose req stays asserted is not re-granted until every other asserting requester has been served once.
- rr_ptr wraps from NUM_REQ-1 to 0.
- drv_busy already high on entry to WAIT_ACCEPT is treated as acceptance.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to WAIT_ACCEPT and to WAIT_DONE, and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES, go to COMPLETE with err=1, rdata unchanged, drv_start=0. rr_ptr advances normally.
- Without the macro: no counter, both wait states wait indefinitely, err is tied to 0.

Test Plan:
- Reset, then req=4'b0001, rw=1, addr=7'h50 -> gnt=0001, drv_addr=7'h50, drv_rw=1, drv_start high until model busy rises. Model busy high for 40 cycles with data_out=8'hA5 -> done[0] 2 cycles after busy falls, rdata=8'hA5, err=0.
- req=4'b1111 held continuously, rr_ptr=0 -> grant order 0,1,2,3,0. Each done only on the granted bit; gnt never multi-hot.
- Write: req[2], rw=0, wdata=8'h3C -> drv_wdata=8'h3C. On done[2], rdata=8'h00.
- req[1] deasserted and req_addr[1] changed mid-WAIT_DONE -> drv_addr unchanged, done[1] still pulses, then return to IDLE.
- rst_n low during WAIT_DONE -> next cycle state IDLE, gnt=0, drv_start=0, no done pulse. After reset release, a new request is granted from rr_ptr=0.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): model never asserts busy -> done with err=1 at cycle 50 of WAIT_ACCEPT, drv_start=0. Without the macro, same stimulus -> still in WAIT_ACCEPT after 1000 cycles.
